// File: rtl/caf_pkg.sv
// rtl/caf_pkg.sv - shared state encoding and sizing helpers for the CAF peak search
package caf_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_OUTPUT = 2'd2
  } caf_state_e;

  localparam int CAF_I_BITS = 24;
  localparam int CAF_Q_BITS = 24;
  localparam int CAF_LENGTH = 5;
  localparam int CAF_FOAS   = 3;

  // Magnitude-squared width: the larger square plus one carry bit for the sum.
  function automatic int caf_mag_bits(input int ib, input int qb);
    return 2 * ((ib > qb) ? ib : qb) + 1;
  endfunction

  function automatic int caf_frame_beats(input int f, input int l);
    return f * l;
  endfunction

  localparam int MAG_BITS    = caf_mag_bits(CAF_I_BITS, CAF_Q_BITS);
  localparam int FRAME_BEATS = caf_frame_beats(CAF_FOAS, CAF_LENGTH);

endpackage

// File: rtl/caf_mag_sq.sv
// rtl/caf_mag_sq.sv - two-stage i^2+q^2 pipeline with lag/freq tag passthrough
module caf_mag_sq
  import caf_pkg::*;
#(
  parameter int i_bits    = CAF_I_BITS,
  parameter int q_bits    = CAF_Q_BITS,
  parameter int lag_bits  = 3,
  parameter int freq_bits = 3,
  parameter int mag_bits  = MAG_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic signed [i_bits-1:0]   ci_i,
  input  logic signed [q_bits-1:0]   cq_i,
  input  logic [lag_bits-1:0]        lag_i,
  input  logic [freq_bits-1:0]       freq_i,
  output logic                       valid_o,
  output logic [mag_bits-1:0]        mag_o,
  output logic [lag_bits-1:0]        lag_o,
  output logic [freq_bits-1:0]       freq_o
);

  localparam int IP = 2 * i_bits;
  localparam int QP = 2 * q_bits;

  logic signed [IP-1:0]  ci_x, ii_d, ii_q;
  logic signed [QP-1:0]  cq_x, qq_d, qq_q;
  logic [mag_bits-1:0]   mag_d, mag_q;
  logic                  s1_valid_q, s2_valid_q;
  logic [lag_bits-1:0]   s1_lag_q, s2_lag_q;
  logic [freq_bits-1:0]  s1_freq_q, s2_freq_q;

  // Squares are taken at double width so -2^(n-1) squared (2^(2n-2)) stays exact;
  // both squares are non-negative, so the sum is formed zero-extended.
  always_comb begin
    ci_x  = IP'(ci_i);
    cq_x  = QP'(cq_i);
    ii_d  = ci_x * ci_x;
    qq_d  = cq_x * cq_x;
    mag_d = mag_bits'($unsigned(ii_q)) + mag_bits'($unsigned(qq_q));
  end

  // Stage 1: register the two squares and their tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      ii_q       <= '0;
      qq_q       <= '0;
      s1_lag_q   <= '0;
      s1_freq_q  <= '0;
    end else begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        ii_q      <= ii_d;
        qq_q      <= qq_d;
        s1_lag_q  <= lag_i;
        s1_freq_q <= freq_i;
      end
    end
  end

  // Stage 2: register the sum and forward the tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      mag_q      <= '0;
      s2_lag_q   <= '0;
      s2_freq_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        mag_q     <= mag_d;
        s2_lag_q  <= s1_lag_q;
        s2_freq_q <= s1_freq_q;
      end
    end
  end

  assign valid_o = s2_valid_q;
  assign mag_o   = mag_q;
  assign lag_o   = s2_lag_q;
  assign freq_o  = s2_freq_q;

endmodule

// File: rtl/caf_peak_search.sv
// rtl/caf_peak_search.sv - frame-wide peak of |c|^2 with lag/freq tags on a valid/ready output
module caf_peak_search
  import caf_pkg::*;
#(
  parameter int i_bits              = CAF_I_BITS,
  parameter int q_bits              = CAF_Q_BITS,
  parameter int length              = CAF_LENGTH,
  parameter int length_counter_bits = 3,
  parameter int foas                = CAF_FOAS,
  parameter int foas_counter_bits   = 3,
  parameter int out_max_bits        = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           m_axis_tvalid,
  input  logic signed [i_bits-1:0]       ci,
  input  logic signed [q_bits-1:0]       cq,
  output logic                           s_axis_tready,
  output logic                           s_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [out_max_bits-1:0]        out_max,
  output logic [length_counter_bits-1:0] index,
  output logic [foas_counter_bits-1:0]   freq_index
);

  localparam int MB = caf_mag_bits(i_bits, q_bits);
  localparam logic [length_counter_bits-1:0] LAST_LAG  = length_counter_bits'(length - 1);
  localparam logic [foas_counter_bits-1:0]   LAST_FREQ = foas_counter_bits'(foas - 1);

  caf_state_e                     state_q, state_d;
  logic                           tready_q, tvalid_q;
  logic [length_counter_bits-1:0] lag_q, lag_d;
  logic [foas_counter_bits-1:0]   freq_q, freq_d;
  logic                           accept, last_beat;
  logic                           load_out, clear_frame;

  logic                           p_valid;
  logic [MB-1:0]                  p_mag;
  logic [length_counter_bits-1:0] p_lag;
  logic [foas_counter_bits-1:0]   p_freq;
  logic                           p_first, p_last, p_wins;

  logic [MB-1:0]                  max_q;
  logic [length_counter_bits-1:0] max_lag_q;
  logic [foas_counter_bits-1:0]   max_freq_q;
  logic                           done_q;

  logic [out_max_bits-1:0]        out_max_q;
  logic [length_counter_bits-1:0] index_q;
  logic [foas_counter_bits-1:0]   freq_index_q;

  assign accept    = m_axis_tvalid && tready_q;
  assign last_beat = (lag_q == LAST_LAG) && (freq_q == LAST_FREQ);

  caf_mag_sq #(
    .i_bits    (i_bits),
    .q_bits    (q_bits),
    .lag_bits  (length_counter_bits),
    .freq_bits (foas_counter_bits),
    .mag_bits  (MB)
  ) u_mag_sq (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (accept),
    .ci_i    (ci),
    .cq_i    (cq),
    .lag_i   (lag_q),
    .freq_i  (freq_q),
    .valid_o (p_valid),
    .mag_o   (p_mag),
    .lag_o   (p_lag),
    .freq_o  (p_freq)
  );

  // The tags identify frame position, so the first beat and the last beat are
  // recognised at the compare stage without a separate marker bit.
  assign p_first = (p_lag == '0) && (p_freq == '0);
  assign p_last  = (p_lag == LAST_LAG) && (p_freq == LAST_FREQ);
  assign p_wins  = p_valid && (p_first || (p_mag > max_q));

  // Next-state logic: frame counters advance per accepted beat, frequency-major.
  always_comb begin
    state_d     = state_q;
    lag_d       = lag_q;
    freq_d      = freq_q;
    load_out    = 1'b0;
    clear_frame = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (lag_q == LAST_LAG) begin
            lag_d  = '0;
            freq_d = (freq_q == LAST_FREQ) ? '0 : freq_q + 1'b1;
          end else begin
            lag_d = lag_q + 1'b1;
          end
          if (last_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (done_q) begin
          load_out = 1'b1;
          state_d  = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (m_axis_tready) begin
          clear_frame = 1'b1;
          lag_d       = '0;
          freq_d      = '0;
          state_d     = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        lag_d   = '0;
        freq_d  = '0;
      end
    endcase
  end

  // State, counters and the registered handshake flags (derived from next state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_ACCUM;
      lag_q    <= '0;
      freq_q   <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lag_q    <= lag_d;
      freq_q   <= freq_d;
      tready_q <= (state_d == ST_ACCUM);
      tvalid_q <= (state_d == ST_OUTPUT);
    end
  end

  // Running maximum: strict compare keeps the earliest of equal peaks.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_frame) begin
      max_q      <= '0;
      max_lag_q  <= '0;
      max_freq_q <= '0;
      done_q     <= 1'b0;
    end else begin
      if (p_wins) begin
        max_q      <= p_mag;
        max_lag_q  <= p_lag;
        max_freq_q <= p_freq;
      end
      if (p_valid && p_last) begin
        done_q <= 1'b1;
      end else if (load_out) begin
        done_q <= 1'b0;
      end
    end
  end

  // Output holding registers, loaded once per frame and stable through OUTPUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_max_q    <= '0;
      index_q      <= '0;
      freq_index_q <= '0;
    end else if (load_out) begin
      out_max_q    <= out_max_bits'(max_q);
      index_q      <= max_lag_q;
      freq_index_q <= max_freq_q;
    end
  end

  assign s_axis_tready = tready_q;
  assign s_axis_tvalid = tvalid_q;
  assign out_max       = out_max_q;
  assign index         = index_q;
  assign freq_index    = freq_index_q;

endmodule

// File: tb/tb_caf_peak_search.sv
// tb/tb_caf_peak_search.sv - randomized self-checking bench for caf_peak_search
module tb_caf_peak_search;
  import caf_pkg::*;

  localparam int NB = FRAME_BEATS;
  localparam int L  = CAF_LENGTH;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               m_axis_tvalid;
  logic signed [23:0] ci, cq;
  logic               s_axis_tready, s_axis_tvalid;
  logic               m_axis_tready;
  logic [63:0]        out_max;
  logic [2:0]         index;
  logic [2:0]         freq_index;

  int vectors     = 0;
  int miscompares = 0;
  int ci_a[NB];
  int cq_a[NB];

  always #5 clk = ~clk;

  caf_peak_search dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_axis_tvalid (m_axis_tvalid),
    .ci            (ci),
    .cq            (cq),
    .s_axis_tready (s_axis_tready),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .out_max       (out_max),
    .index         (index),
    .freq_index    (freq_index)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int rnd24();
    int v;
    v = $urandom;
    return v >>> 8;
  endfunction

  // Reference: scan the frame in arrival order, keep the first strictly-larger magnitude.
  task automatic model(output longint m, output int li, output int fi);
    longint mag;
    m  = -1;
    li = 0;
    fi = 0;
    for (int k = 0; k < NB; k++) begin
      mag = longint'(ci_a[k]) * longint'(ci_a[k]) + longint'(cq_a[k]) * longint'(cq_a[k]);
      if (mag > m) begin
        m  = mag;
        li = k % L;
        fi = k / L;
      end
    end
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < NB; k++) begin
      ci_a[k] = v;
      cq_a[k] = v;
    end
  endtask

  // Drives n beats with random valid gaps; returns at the negedge after the last acceptance.
  task automatic send_beats(input int n, input int gap_pct);
    int  k;
    int  guard;
    bit  acc;
    k     = 0;
    guard = 0;
    while (k < n && guard < 4000) begin
      @(negedge clk);
      m_axis_tvalid = ($urandom_range(0, 99) >= gap_pct);
      m_axis_tready = 1'($urandom_range(0, 1));
      ci            = 24'(ci_a[k]);
      cq            = 24'(cq_a[k]);
      acc           = m_axis_tvalid && s_axis_tready;
      @(posedge clk);
      if (acc) k++;
      guard++;
    end
    if (k < n) check_eq("send_timeout", 64'(k), 64'(n));
    @(negedge clk);
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  task automatic run_frame(input string name, input int gap_pct, input int bp);
    longint em;
    int     el, ef, lat;
    model(em, el, ef);
    send_beats(NB, gap_pct);
    // Offer junk while the block must refuse input; an accepted beat would corrupt the next frame.
    m_axis_tvalid = 1'b1;
    ci            = 24'(rnd24());
    cq            = 24'(rnd24());
    check_eq({name, "_drain_tready"}, 64'(s_axis_tready), 64'd0);
    lat = 0;
    while (!s_axis_tvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({name, "_latency"}, 64'(lat), 64'd3);
    check_eq({name, "_out_max"}, out_max, 64'(em));
    check_eq({name, "_index"}, 64'(index), 64'(el));
    check_eq({name, "_freq_index"}, 64'(freq_index), 64'(ef));
    for (int c = 0; c < bp; c++) begin
      @(negedge clk);
      check_eq({name, "_bp_tvalid"}, 64'(s_axis_tvalid), 64'd1);
      check_eq({name, "_bp_tready"}, 64'(s_axis_tready), 64'd0);
      check_eq({name, "_bp_out_max"}, out_max, 64'(em));
      check_eq({name, "_bp_tags"}, 64'({index, freq_index}), 64'({3'(el), 3'(ef)}));
    end
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    check_eq({name, "_post_tvalid"}, 64'(s_axis_tvalid), 64'd0);
    check_eq({name, "_post_tready"}, 64'(s_axis_tready), 64'd1);
  endtask

  task automatic apply_reset(input string name);
    rst_n         = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq({name, "_tvalid"}, 64'(s_axis_tvalid), 64'd0);
    check_eq({name, "_tready"}, 64'(s_axis_tready), 64'd0);
    check_eq({name, "_out_max"}, out_max, 64'd0);
    check_eq({name, "_tags"}, 64'({index, freq_index}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq({name, "_tready_rise"}, 64'(s_axis_tready), 64'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    ci            = '0;
    cq            = '0;

    apply_reset("reset");

    fill(1);
    ci_a[1*L+3] = 100;
    cq_a[1*L+3] = -50;
    run_frame("single", 0, 0);

    fill(0);
    ci_a[0*L+2] = 7;
    ci_a[2*L+4] = 7;
    run_frame("tie", 0, 0);

    fill(0);
    ci_a[2*L+1] = -(1 <<< 23);
    cq_a[2*L+1] = -(1 <<< 23);
    run_frame("extreme", 0, 0);

    for (int k = 0; k < NB; k++) begin
      ci_a[k] = rnd24();
      cq_a[k] = rnd24();
    end
    run_frame("backpressure", 40, 10);

    fill(0);
    run_frame("zero", 30, 2);

    for (int k = 0; k < NB; k++) begin
      ci_a[k] = 5000 + k;
      cq_a[k] = -5000;
    end
    send_beats(7, 20);
    apply_reset("midreset");
    for (int k = 0; k < NB; k++) begin
      ci_a[k] = $urandom_range(0, 200) - 100;
      cq_a[k] = $urandom_range(0, 200) - 100;
    end
    ci_a[2*L+0] = 1000;
    run_frame("after_reset", 20, 1);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NB; k++) begin
        ci_a[k] = rnd24();
        cq_a[k] = rnd24();
      end
      run_frame("random", $urandom_range(0, 50), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
